sensor_snapshot_scheduler: RTL

Sequences the 8-sensor snapshot latch: a periodic timer or a manual trigger issues the one-cycle update strobe. The block then registers the 256-bit concatenated sensor word and streams the enabled 32-bit sensor words to a downstream consumer over a valid/ready handshake. It sits between the per-sensor decoders' snapshot latch and the host/communication interface. It counts triggers lost because a frame was still in progress.

---
 rtl/sensor_snapshot_scheduler.sv | 103 ++++++++++
 1 files changed

// File: rtl/sensor_snapshot_scheduler.sv
// sensor_snapshot_scheduler: periodic/manual snapshot capture, then streams the
// enabled sensor words over valid/ready and counts requests dropped mid-frame.
module sensor_snapshot_scheduler #(
   parameter logic [31:0] PERIOD_CYCLES = 32'd50000,
   parameter int          NUM_SENSORS   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          trigger,
   input  logic [NUM_SENSORS-1:0]        sensor_mask,
   output logic                          update,
   input  logic [32*NUM_SENSORS-1:0]     snapshot,
   output logic [31:0]                   word_data,
   output logic [2:0]                    word_index,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic                          word_last,
   output logic                          busy,
   output logic [15:0]                   overrun_count
);
   typedef enum logic [1:0] {IDLE, LATCH, CAPTURE, STREAM} state_t;
   state_t state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [NUM_SENSORS-1:0] mask_q, mask_d;
   logic [32*NUM_SENSORS-1:0] snap_q, snap_d;
   logic [2:0] idx_q, idx_d, first_idx, next_idx;
   logic [31:0] data_q, data_d;
   logic [15:0] ovr_q, ovr_d;
   logic tick, req, last;

   // Lowest set bit of m at or above position from.
   function automatic logic [2:0] first_set(input logic [NUM_SENSORS-1:0] m, input logic [3:0] from);
      first_set = 3'd0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--)
         if (m[i] && i >= int'(from)) first_set = 3'(i);
   endfunction

   always_comb begin
      tick      = enable && (timer_q == PERIOD_CYCLES - 32'd1);
      req       = tick || trigger;
      timer_d   = (enable && !tick) ? timer_q + 32'd1 : 32'd0;
      first_idx = first_set(mask_q, 4'd0);
      next_idx  = first_set(mask_q, {1'b0, idx_q} + 4'd1);
      last      = (mask_q >> ({1'b0, idx_q} + 4'd1)) == '0;
      ovr_d     = (req && state_q != IDLE && ovr_q != 16'hFFFF) ? ovr_q + 16'd1 : ovr_q;
      state_d   = state_q;
      mask_d    = mask_q;
      snap_d    = snap_q;
      idx_d     = idx_q;
      data_d    = data_q;
      case (state_q)
         IDLE:
            if (req && |sensor_mask) begin
               mask_d  = sensor_mask;
               state_d = LATCH;
            end
         LATCH: state_d = CAPTURE;
         CAPTURE: begin
            snap_d  = snapshot;
            idx_d   = first_idx;
            data_d  = snapshot[{first_idx, 5'd0} +: 32];
            state_d = STREAM;
         end
         STREAM:
            if (word_ready) begin
               if (last) state_d = IDLE;
               else begin
                  idx_d  = next_idx;
                  data_d = snap_q[{next_idx, 5'd0} +: 32];
               end
            end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         mask_q  <= '0;
         snap_q  <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         ovr_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         mask_q  <= mask_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   assign update        = state_q == LATCH;
   assign busy          = state_q != IDLE;
   assign word_valid    = state_q == STREAM;
   assign word_index    = word_valid ? idx_q : 3'd0;
   assign word_last     = word_valid && last;
   assign word_data     = data_q;
   assign overrun_count = ovr_q;
endmodule
